fcta_s2mm_downsizer: RTL and testbench

- Output-side stage directly downstream of the FCTA accelerator's result stream (m_axis_s2mm, AXIS_BW wide).
- Accepts one wide result beat per handshake and emits it to the S2MM DMA as RATIO = IN_BW/OUT_BW narrow beats, least-significant slice first.
- Preserves packet framing: tlast only on the final slice of a wide beat that carried tlast.
- Sustains one narrow beat per cycle under continuous valid/ready, with no bubble between wide beats.

---
 rtl/fcta_s2mm_downsizer_if.sv | 26 ++
 rtl/fcta_s2mm_downsizer.sv | 107 ++++++++++
 tb/tb_fcta_s2mm_downsizer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fcta_s2mm_downsizer_if.sv
// Stream bundle between the FCTA result stream (wide side) and the S2MM DMA (narrow side).
interface fcta_s2mm_downsizer_if #(
  parameter int IN_BW  = 1024,
  parameter int OUT_BW = 256
);
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic [IN_BW-1:0]  s_axis_tdata;
  logic              s_axis_tready;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic [OUT_BW-1:0] m_axis_tdata;
  logic              m_axis_tready;

  // downsizer side
  modport slave (
    input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata
  );

  // environment side: accelerator source plus DMA sink
  modport master (
    output s_axis_tvalid, s_axis_tlast, s_axis_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata
  );
endinterface

// File: rtl/fcta_s2mm_downsizer.sv
// Splits each wide result beat into RATIO narrow beats, LSB slice first, keeping tlast on the final slice.
// Optional completed-packet counter xfer_cnt is built when FCTA_DWN_CNT_EN is defined.
module fcta_s2mm_downsizer #(
  parameter int IN_BW  = 1024,
  parameter int OUT_BW = 256
`ifdef FCTA_DWN_CNT_EN
  ,
  parameter int CNT_BW = 32
`endif
) (
  input  logic clk,
  input  logic rst,
`ifdef FCTA_DWN_CNT_EN
  output logic [CNT_BW-1:0] xfer_cnt,
`endif
  fcta_s2mm_downsizer_if.slave bus
);

  localparam int RATIO  = IN_BW / OUT_BW;
  localparam int IDX_BW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(RATIO - 1);
  localparam logic [IDX_BW-1:0] IDX_ZERO = {IDX_BW{1'b0}};
  localparam logic [IDX_BW-1:0] IDX_ONE  = IDX_BW'(1);

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                        state_r;
  logic [RATIO-1:0][OUT_BW-1:0]  data_r;
  logic                          tlast_r;
  logic [IDX_BW-1:0]             idx_r;

  logic full_s;
  logic last_slice_s;
  logic in_hs_s;
  logic out_hs_s;

  assign full_s       = (state_r == DRAIN);
  assign last_slice_s = (idx_r == LAST_IDX);

  // Ready reopens while the final slice is leaving so wide beats can follow without a bubble.
  assign bus.s_axis_tready = !full_s || (bus.m_axis_tready && last_slice_s);
  assign in_hs_s           = bus.s_axis_tvalid && bus.s_axis_tready;
  assign out_hs_s          = full_s && bus.m_axis_tready;

  assign bus.m_axis_tvalid = full_s;
  assign bus.m_axis_tdata  = data_r[idx_r];
  assign bus.m_axis_tlast  = full_s && tlast_r && last_slice_s;

  // Slice-sequencing FSM: fill state, slice index and captured tlast.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
      idx_r   <= IDX_ZERO;
      tlast_r <= 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_hs_s) begin
            tlast_r <= bus.s_axis_tlast;
            idx_r   <= IDX_ZERO;
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_hs_s) begin
            if (!last_slice_s) begin
              idx_r <= idx_r + IDX_ONE;
            end else if (in_hs_s) begin
              tlast_r <= bus.s_axis_tlast;
              idx_r   <= IDX_ZERO;
            end else begin
              idx_r   <= IDX_ZERO;
              state_r <= EMPTY;
            end
          end
        end
        default: begin
          state_r <= EMPTY;
          idx_r   <= IDX_ZERO;
          tlast_r <= 1'b0;
        end
      endcase
    end
  end

  // Wide data holding register; left unreset since it is only observed while full.
  always_ff @(posedge clk) begin
    if (in_hs_s) begin
      data_r <= bus.s_axis_tdata;
    end
  end

`ifdef FCTA_DWN_CNT_EN
  // Completed-packet counter, advancing on every accepted narrow tlast beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= {CNT_BW{1'b0}};
    end else if (out_hs_s && bus.m_axis_tlast) begin
      xfer_cnt <= xfer_cnt + CNT_BW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fcta_s2mm_downsizer.sv
// Randomised self-checking bench for fcta_s2mm_downsizer (RATIO=4, 8-bit slices) against a slice-queue model.
// Define FCTA_DWN_CNT_EN to also check the xfer_cnt packet counter (reduced 3-bit width).
module tb_fcta_s2mm_downsizer;

  localparam int IN_BW  = 32;
  localparam int OUT_BW = 8;
  localparam int RATIO  = IN_BW / OUT_BW;
  localparam int CNT_BW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  fcta_s2mm_downsizer_if #(.IN_BW(IN_BW), .OUT_BW(OUT_BW)) bus ();

`ifdef FCTA_DWN_CNT_EN
  logic [CNT_BW-1:0] xfer_cnt;

  fcta_s2mm_downsizer #(.IN_BW(IN_BW), .OUT_BW(OUT_BW), .CNT_BW(CNT_BW)) dut (
    .clk      (clk),
    .rst      (rst),
    .xfer_cnt (xfer_cnt),
    .bus      (bus.slave)
  );
`else
  fcta_s2mm_downsizer #(.IN_BW(IN_BW), .OUT_BW(OUT_BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
`endif

  // Model: every accepted wide beat becomes RATIO pending {last, data} narrow beats.
  logic [OUT_BW:0] exp_q[$];
  int exp_cnt  = 0;
  int n_checks = 0;
  int n_errors = 0;
  int rdy_mode = 0;
  int pat_idx  = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic next_rdy();
    logic r;
    case (rdy_mode)
      0: r = 1'b1;
      1: begin
        case (pat_idx % 4)
          0: r = 1'b1;
          1: r = 1'b0;
          2: r = 1'b0;
          default: r = 1'b1;
        endcase
        pat_idx++;
      end
      default: r = 1'($urandom_range(0, 1));
    endcase
    return r;
  endfunction

  // One clock: drive at the falling edge, check outputs, then advance the model past the next rising edge.
  task automatic cycle(input logic vld, input logic [IN_BW-1:0] dat, input logic lst, output logic acc);
    logic rdy;
    logic exp_valid;
    logic exp_ready;
    logic [OUT_BW:0] head;
    rdy = next_rdy();
    @(negedge clk);
    bus.s_axis_tvalid = vld;
    bus.s_axis_tdata  = dat;
    bus.s_axis_tlast  = lst;
    bus.m_axis_tready = rdy;
    #1;
    exp_valid = (exp_q.size() != 0);
    exp_ready = (exp_q.size() == 0) || ((exp_q.size() == 1) && rdy);
    check_val("m_tvalid", 64'(bus.m_axis_tvalid), 64'(exp_valid));
    check_val("s_tready", 64'(bus.s_axis_tready), 64'(exp_ready));
    if (exp_valid) begin
      head = exp_q[0];
      check_val("m_tdata", 64'(bus.m_axis_tdata), 64'(head[OUT_BW-1:0]));
      check_val("m_tlast", 64'(bus.m_axis_tlast), 64'(head[OUT_BW]));
    end else begin
      check_val("m_tlast_idle", 64'(bus.m_axis_tlast), 64'd0);
    end
`ifdef FCTA_DWN_CNT_EN
    check_val("xfer_cnt", 64'(xfer_cnt), 64'(exp_cnt));
`endif
    acc = vld && exp_ready;
    if (exp_valid && rdy) begin
      head = exp_q.pop_front();
      if (head[OUT_BW]) exp_cnt = (exp_cnt + 1) % (1 << CNT_BW);
    end
    if (acc) begin
      for (int k = 0; k < RATIO; k++) begin
        exp_q.push_back({(lst && (k == RATIO - 1)), dat[k*OUT_BW +: OUT_BW]});
      end
    end
  endtask

  task automatic send_beat(input logic [IN_BW-1:0] dat, input logic lst);
    logic acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 64) begin
      cycle(1'b1, dat, lst, acc);
      tries++;
    end
    if (!acc) check_val("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, IN_BW'($urandom), 1'($urandom_range(0, 1)), acc);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 64) begin
      idle(1);
      t++;
    end
    if (t >= 64) check_val("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.m_axis_tready = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_val("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check_val("rst_m_tlast", 64'(bus.m_axis_tlast), 64'd0);
    check_val("rst_s_tready", 64'(bus.s_axis_tready), 64'd1);
`ifdef FCTA_DWN_CNT_EN
    check_val("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // single beat, sink always ready
    rdy_mode = 0;
    send_beat(32'hA3A2A1A0, 1'b1);
    drain();

    // two back-to-back beats with tvalid held
    send_beat(32'h13121110, 1'b0);
    send_beat(32'h23222120, 1'b1);
    drain();

    // backpressure 1,0,0,1 pattern
    rdy_mode = 1;
    pat_idx  = 0;
    send_beat(32'h33323130, 1'b1);
    drain();
    rdy_mode = 0;

    // input stall then fresh beat
    idle(3);
    send_beat(32'h43424140, 1'b0);
    drain();

    // reset while the beat is draining
    send_beat(32'h03020100, 1'b1);
    idle(1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("midrst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check_val("midrst_s_tready", 64'(bus.s_axis_tready), 64'd1);
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    idle(4);

`ifdef FCTA_DWN_CNT_EN
    // 5 then 9 packets of two wide beats each; counter is 3 bits wide
    for (int p = 0; p < 9; p++) begin
      send_beat(IN_BW'($urandom), 1'b0);
      send_beat(IN_BW'($urandom), 1'b1);
      if (p == 4) begin
        drain();
        @(negedge clk);
        #1 check_val("xfer_cnt_5", 64'(xfer_cnt), 64'd5);
      end
    end
    drain();
    @(negedge clk);
    #1 check_val("xfer_cnt_wrap", 64'(xfer_cnt), 64'd1);
`endif

    // randomised traffic with random sink readiness and input gaps
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send_beat(IN_BW'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
